// File: rtl/fp16_pkg.sv
// fp16_pkg: shared types for the fp16 adder driver.
package fp16_pkg;

   typedef logic [15:0] fp16_t;

   localparam int unsigned FP16_SIGN_BIT = 15;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } drv_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous clear; DEPTH must be a power of two.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   clear,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_pop  = pop && (r_count != '0);
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign w_push = push && ((r_count != CW'(DEPTH)) || w_pop);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign full  = (r_count == CW'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;

endmodule

// File: rtl/fp16_add_drv.sv
// fp16_add_drv: issue driver and in-order result collector for the fp16_add wrapper.
// Define FP16_DRV_SUB_EN to add the s_op port (subtract by flipping the sign of B).
module fp16_add_drv
   import fp16_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [15:0]      s_a,
   input  logic [15:0]      s_b,
   input  logic [TAG_W-1:0] s_tag,
`ifdef FP16_DRV_SUB_EN
   input  logic             s_op,
`endif
   output logic             add_valid,
   output logic [15:0]      add_a,
   output logic [15:0]      add_b,
   input  logic [15:0]      add_y,
   input  logic             add_ready,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [15:0]      m_y,
   output logic [TAG_W-1:0] m_tag,
   input  logic             flush,
   output logic             busy,
   output logic             err
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned RW = TAG_W + 16;

   drv_state_t       r_state;
   drv_state_t       w_state_d;
   logic [CW-1:0]    r_occ;
   logic [CW-1:0]    w_occ_d;
   logic             r_add_valid;
   fp16_t            r_add_a;
   fp16_t            r_add_b;
   fp16_t            w_b;
   logic             r_err;

   logic             w_s_ready;
   logic             w_accept;
   logic             w_m_valid;
   logic             w_m_pop;
   logic             w_tag_pop;
   logic             w_res_push;
   logic             w_flush_run;
   logic             w_tag_full;
   logic             w_tag_empty;
   logic [CW-1:0]    w_tag_count;
   logic [TAG_W-1:0] w_tag_head;
   logic             w_res_full;
   logic             w_res_empty;
   logic [CW-1:0]    w_res_count;
   logic [RW-1:0]    w_res_head;
   logic             w_unused;

   // occ counts tags in flight plus buffered results, so every issued op owns a result slot.
   assign w_s_ready   = !rst && (r_state == RUN) && (r_occ < CW'(DEPTH)) && !w_tag_full;
   assign w_accept    = s_valid && w_s_ready;
   assign w_m_valid   = !rst && (r_state == RUN) && !w_res_empty;
   assign w_m_pop     = w_m_valid && m_ready;
   assign w_tag_pop   = add_ready && !w_tag_empty;
   assign w_res_push  = w_tag_pop && (r_state == RUN);
   assign w_flush_run = flush && (r_state == RUN);

   always_comb begin
      w_b = s_b;
`ifdef FP16_DRV_SUB_EN
      if (s_op) begin
         w_b[FP16_SIGN_BIT] = ~s_b[FP16_SIGN_BIT];
      end
`endif
   end

   always_comb begin
      w_state_d = r_state;
      w_occ_d   = r_occ;
      case (r_state)
         RUN: begin
            if (flush) begin
               w_state_d = DRAIN;
               // Buffered results vanish; only ops still owed by the adder remain counted.
               w_occ_d   = w_tag_count + CW'(w_accept) - CW'(w_tag_pop);
            end else begin
               w_occ_d   = r_occ + CW'(w_accept) - CW'(w_m_pop);
            end
         end
         DRAIN: begin
            if (r_occ == '0) begin
               w_state_d = RUN;
            end else if (w_tag_pop) begin
               w_occ_d = r_occ - CW'(1);
            end
         end
         default: begin
            w_state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= RUN;
         r_occ       <= '0;
         r_add_valid <= 1'b0;
         r_add_a     <= '0;
         r_add_b     <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_occ       <= w_occ_d;
         r_add_valid <= w_accept;
         if (w_accept) begin
            r_add_a <= s_a;
            r_add_b <= w_b;
         end
         if (add_ready && w_tag_empty) begin
            r_err <= 1'b1;
         end
      end
   end

   sync_fifo #(
      .WIDTH (TAG_W),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_accept),
      .pop   (w_tag_pop),
      .clear (1'b0),
      .din   (s_tag),
      .dout  (w_tag_head),
      .full  (w_tag_full),
      .empty (w_tag_empty),
      .count (w_tag_count)
   );

   sync_fifo #(
      .WIDTH (RW),
      .DEPTH (DEPTH)
   ) u_res_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_res_push),
      .pop   (w_m_pop),
      .clear (w_flush_run),
      .din   ({w_tag_head, add_y}),
      .dout  (w_res_head),
      .full  (w_res_full),
      .empty (w_res_empty),
      .count (w_res_count)
   );

   assign s_ready   = w_s_ready;
   assign add_valid = r_add_valid;
   assign add_a     = r_add_a;
   assign add_b     = r_add_b;
   assign m_valid   = w_m_valid;
   assign m_y       = w_m_valid ? w_res_head[15:0] : '0;
   assign m_tag     = w_m_valid ? w_res_head[RW-1:16] : '0;
   assign busy      = (r_state == DRAIN);
   assign err       = r_err;
   assign w_unused  = ^{w_res_full, w_res_count};

endmodule

// File: tb/tb_fp16_add_drv.sv
// tb_fp16_add_drv: randomized bench for fp16_add_drv against a latency-4 adder model and
// an in-order scoreboard built from integer-valued fp16 operands.
`timescale 1ns/1ps
module tb_fp16_add_drv;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned TAG_W = 4;

   logic             clk;
   logic             rst;
   logic             s_valid;
   logic             s_ready;
   logic [15:0]      s_a;
   logic [15:0]      s_b;
   logic [TAG_W-1:0] s_tag;
   logic             s_op;
   logic             add_valid;
   logic [15:0]      add_a;
   logic [15:0]      add_b;
   logic [15:0]      add_y;
   logic             add_ready;
   logic             m_valid;
   logic             m_ready;
   logic [15:0]      m_y;
   logic [TAG_W-1:0] m_tag;
   logic             flush;
   logic             busy;
   logic             err;
   logic             spur;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int n_acc    = 0;
   int n_issue  = 0;
   int acc_edge = 0;
   logic [15:0] last_y     = '0;
   logic [15:0] last_add_b = '0;
   logic [TAG_W-1:0] last_tag = '0;

   logic [TAG_W+15:0] exp_q [$];
   logic [31:0]       iss_q [$];
   int                pop_edges [$];

   logic [3:0]  st_v;
   logic [15:0] st_y [4];

   fp16_add_drv #(
      .DEPTH (DEPTH),
      .TAG_W (TAG_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_a       (s_a),
      .s_b       (s_b),
      .s_tag     (s_tag),
`ifdef FP16_DRV_SUB_EN
      .s_op      (s_op),
`endif
      .add_valid (add_valid),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_y     (add_y),
      .add_ready (add_ready),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_y       (m_y),
      .m_tag     (m_tag),
      .flush     (flush),
      .busy      (busy),
      .err       (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int fp16_to_int(input logic [15:0] h);
      int e;
      int v;
      e = int'(h[14:10]);
      if (e == 0) return 0;
      v = 1024 + int'(h[9:0]);
      if (e >= 25) v = v <<< (e - 25);
      else         v = v >>> (25 - e);
      return h[15] ? -v : v;
   endfunction

   function automatic logic [15:0] int_to_fp16(input int v);
      int m;
      int e;
      int mant;
      if (v == 0) return 16'h0000;
      m = (v < 0) ? -v : v;
      e = 0;
      while ((m >> (e + 1)) != 0) e++;
      mant = (e <= 10) ? ((m << (10 - e)) & 1023) : ((m >> (e - 10)) & 1023);
      return {(v < 0), 5'(e + 15), 10'(mant)};
   endfunction

   function automatic logic [15:0] rnd();
      return int_to_fp16(int'($urandom_range(0, 1023)));
   endfunction

   // Adder model: fixed 4-cycle latency, exact for the integer operands used here.
   always @(posedge clk) begin
      if (rst) begin
         st_v <= '0;
      end else begin
         st_v     <= {st_v[2:0], add_valid};
         st_y[0]  <= int_to_fp16(fp16_to_int(add_a) + fp16_to_int(add_b));
         st_y[1]  <= st_y[0];
         st_y[2]  <= st_y[1];
         st_y[3]  <= st_y[2];
      end
   end
   assign add_ready = st_v[3] | spur;
   assign add_y     = st_y[3];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor: samples on the falling edge what the next rising edge will transfer.
   initial begin
      logic              op;
      int                bi;
      logic [31:0]       ie;
      logic [TAG_W+15:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            iss_q.delete();
         end else begin
            if (add_valid) begin
               check("iss_pending", 32'(iss_q.size() != 0), 1);
               if (iss_q.size() != 0) begin
                  ie = iss_q.pop_front();
                  check("add_a", 32'(add_a), 32'(ie[31:16]));
                  check("add_b", 32'(add_b), 32'(ie[15:0]));
               end
               last_add_b = add_b;
               n_issue++;
            end
            if (s_valid && s_ready) begin
               op = 1'b0;
`ifdef FP16_DRV_SUB_EN
               op = s_op;
`endif
               bi = op ? -fp16_to_int(s_b) : fp16_to_int(s_b);
               exp_q.push_back({s_tag, int_to_fp16(fp16_to_int(s_a) + bi)});
               iss_q.push_back({s_a, op ? (s_b ^ 16'h8000) : s_b});
               n_acc++;
               acc_edge = cyc + 1;
            end
            if (m_valid && m_ready) begin
               check("m_pending", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("m_y", 32'(m_y), 32'(e[15:0]));
                  check("m_tag", 32'(m_tag), 32'(e[TAG_W+15:16]));
               end
               last_y   = m_y;
               last_tag = m_tag;
               pop_edges.push_back(cyc + 1);
            end
            if (flush && !busy) exp_q.delete();
         end
      end
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [TAG_W-1:0] t,
                       input logic op);
      int n;
      n       = 0;
      s_valid = 1'b1;
      s_a     = a;
      s_b     = b;
      s_tag   = t;
      s_op    = op;
      @(negedge clk);
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", 32'(s_ready), 1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic drain_wait(input int maxc);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < maxc) begin
         @(posedge clk);
         n++;
      end
      check("drain_done", 32'(exp_q.size()), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   initial begin
      int   n;
      int   c0;
      logic acc;
      logic pend;
      rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; s_tag = '0; s_op = 1'b0;
      m_ready = 1'b0; flush = 1'b0; spur = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_s_ready", 32'(s_ready), 0);
      check("rst_add_valid", 32'(add_valid), 0);
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_err", 32'(err), 0);
      check("rst_add_ab", {add_a, add_b}, 0);
      check("rst_m_y_tag", {12'h0, m_tag, m_y}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("s_ready_after_rst", 32'(s_ready), 1);
      @(posedge clk);
      #1;

      // Single op: 1.0 + 2.0 = 3.0, popped 6 edges after accept.
      m_ready = 1'b1;
      pop_edges.delete();
      c0 = n_issue;
      send(16'h3C00, 16'h4000, 4'd3, 1'b0);
      drain_wait(50);
      check("single_pops", 32'(pop_edges.size()), 1);
      if (pop_edges.size() == 1) check("single_latency", 32'(pop_edges[0] - acc_edge), 6);
      check("single_y", 32'(last_y), 32'h4200);
      check("single_tag", 32'(last_tag), 3);
      check("single_issue_pulses", 32'(n_issue - c0), 1);

      // Back-to-back: one accept and one result per cycle.
      pop_edges.delete();
      c0 = cyc;
      for (int i = 0; i < 8; i++) send(rnd(), rnd(), TAG_W'(i), 1'b0);
      check("b2b_no_stall", 32'(cyc - c0), 8);
      drain_wait(50);
      check("b2b_pops", 32'(pop_edges.size()), 8);
      if (pop_edges.size() == 8) check("b2b_span", 32'(pop_edges[7] - pop_edges[0]), 7);

      // Backpressure: exactly DEPTH accepts with the consumer stalled.
      m_ready = 1'b0;
      n = 0;
      s_valid = 1'b1; s_a = rnd(); s_b = rnd(); s_tag = '0; s_op = 1'b0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            n++;
            s_a = rnd(); s_b = rnd(); s_tag = TAG_W'(n);
         end
      end
      s_valid = 1'b0;
      check("bp_accepts", 32'(n), DEPTH);
      @(negedge clk);
      check("bp_ready_low", 32'(s_ready), 0);
      @(posedge clk);
      #1 m_ready = 1'b1;
      @(negedge clk);
      check("bp_ready_before_pop", 32'(s_ready), 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_ready_after_pop", 32'(s_ready), 1);
      @(posedge clk);
      #1;
      drain_wait(50);

      // Flush with 2 results buffered and 3 ops in flight.
      m_ready = 1'b0;
      send(rnd(), rnd(), 4'hA, 1'b0);
      send(rnd(), rnd(), 4'hB, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      @(negedge clk);
      check("fl_buffered", 32'(m_valid), 1);
      @(posedge clk);
      #1;
      send(rnd(), rnd(), 4'hC, 1'b0);
      send(rnd(), rnd(), 4'hD, 1'b0);
      send(rnd(), rnd(), 4'hE, 1'b0);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      check("fl_busy", 32'(busy), 1);
      check("fl_s_ready", 32'(s_ready), 0);
      n = 0;
      while (busy && n < 30) begin
         check("fl_drain_m_valid", 32'(m_valid), 0);
         @(negedge clk);
         n++;
      end
      check("fl_busy_done", 32'(busy), 0);
      check("fl_resume_ready", 32'(s_ready), 1);
      check("fl_no_result", 32'(m_valid), 0);
      check("fl_err", 32'(err), 0);
      @(posedge clk);
      #1;
      send(rnd(), rnd(), 4'h5, 1'b0);
      drain_wait(50);

      // Random traffic with random consumer stalls.
      pend = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!pend && $urandom_range(0, 3) != 0) begin
            s_valid = 1'b1; s_a = rnd(); s_b = rnd(); s_tag = TAG_W'($urandom_range(0, 15));
            s_op = 1'($urandom_range(0, 1));
            pend = 1'b1;
         end
         m_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = s_valid && s_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            pend    = 1'b0;
            s_valid = 1'b0;
         end
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      drain_wait(200);

`ifdef FP16_DRV_SUB_EN
      send(16'h4200, 16'h3C00, 4'h9, 1'b1);
      drain_wait(50);
      check("sub_add_b", 32'(last_add_b), 32'hBC00);
      check("sub_y", 32'(last_y), 32'h4000);
`endif

      check("issue_count", 32'(n_issue), 32'(n_acc));
      check("err_clean", 32'(err), 0);

      // Spurious result with nothing outstanding.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      spur = 1'b1;
      @(posedge clk);
      #1 spur = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("spur_err", 32'(err), 1);
         check("spur_m_valid", 32'(m_valid), 0);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("spur_err_cleared", 32'(err), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fp16_add_drv.md
# fp16_add_drv

Issue-side driver and result collector for the `fp16_add` wrapper. It accepts tagged operand pairs over a valid/ready stream and issues them to the adder as single-cycle `valid` pulses. Because the adder has no backpressure, the driver reserves a result slot before each issue. It captures each returned sum with the tag of the oldest outstanding operation and presents results in order on a valid/ready output stream.

## Interface
Parameters:
- `DEPTH`, 8: maximum operations in flight plus buffered results. Power of two, ≥2.
- `TAG_W`, 4: width of the user tag carried alongside each operation.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  operand pair valid.
- `s_ready`  out  1  driver can accept an operand pair.
- `s_a`  in  16  fp16 operand A.
- `s_b`  in  16  fp16 operand B.
- `s_tag`  in  TAG_W  user tag.
- `s_op`  in  1  0 = add, 1 = subtract. Present only with `FP16_DRV_SUB_EN`.
- `add_valid`  out  1  to `fp16_add.valid`.
- `add_a`, `add_b`  out  16  to `fp16_add.a` / `.b`.
- `add_y`  in  16  from `fp16_add.y`.
- `add_ready`  in  1  from `fp16_add.ready` (result valid).
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  consumer accepts result.
- `m_y`  out  16  fp16 sum.
- `m_tag`  out  TAG_W  tag of this result.
- `flush`  in  1  one-cycle request to abandon all work.
- `busy`  out  1  driver is in DRAIN.
- `err`  out  1  sticky: result arrived with no outstanding operation.

## Operation
- FSM states:
  - RUN: normal issue.
  - DRAIN: flushing.
- Occupancy counter `occ` (0..DEPTH):
  - +1 on accept (`s_valid && s_ready`).
  - −1 on result pop (`m_valid && m_ready`).
  - Accept and pop in the same cycle leave `occ` unchanged.
- `s_ready = (state==RUN) && (occ < DEPTH)`. This guarantees every in-flight result has a buffer slot.
- On accept:
  - The issue register loads `s_a`, `s_b` (sign of B possibly inverted, see Configuration).
  - The tag is pushed into the tag FIFO.
  - `add_valid` pulses high for exactly one cycle on the next cycle.
- On `add_ready`:
  - If the tag FIFO is non-empty, pop its head and push `{tag, add_y}` into the result FIFO.
  - If the tag FIFO is empty, set `err` and drop the result.
  - A tag push and pop in the same cycle are both honoured.
- The result FIFO head drives `m_valid`, `m_y`, `m_tag`. Outputs stay stable while `m_valid && !m_ready`.
- `flush` in RUN:
  - Move to DRAIN; the result FIFO is cleared.
  - `occ` is reloaded with the tag-FIFO count (in-flight operations, including any op in the issue register).
  - In DRAIN, `s_ready = 0` and `m_valid = 0`. Each `add_ready` pops the tag FIFO, drops the result and decrements `occ`.
  - Return to RUN the cycle after `occ == 0`.
- `flush` in DRAIN is ignored.
- The driver performs no arithmetic; it passes the 16-bit operands and sum through unchanged, apart from the sign bit of B when subtracting.

## Timing
- Reset values:
  - While `rst` is asserted: `s_ready` = 0, `add_valid` = 0, `m_valid` = 0, `busy` = 0, `err` = 0, and `add_a`/`add_b`/`m_y`/`m_tag` are 0.
  - After reset: state RUN, `occ` = 0, both FIFOs empty.
  - `s_ready` = 1 in the first cycle after `rst` deasserts.
- Accept at edge N → `add_valid` high in cycle N+1.
- `add_ready` at edge M → `m_valid` high in cycle M+1 if the FIFO was empty.
- The driver adds 2 cycles to the adder latency.
- Throughput is one operation per cycle while `occ < DEPTH` and the consumer keeps up.
- `rst` mid-operation discards all state. The adder shares reset, so any stale result arriving afterwards sets `err`.

## Configuration
- `FP16_DRV_SUB_EN` defined:
  - The `s_op` port exists.
  - When `s_op` = 1 at accept, `add_b = {~s_b[15], s_b[14:0]}`, so NaN inputs also have their sign flipped.
- `FP16_DRV_SUB_EN` undefined:
  - No `s_op` port.
  - `add_b = s_b` always.

## Structure
- Package `fp16_pkg`:
  - `typedef logic [15:0] fp16_t`.
  - `FP16_SIGN_BIT = 15`.
  - State enum `drv_state_t {RUN, DRAIN}`.
- Sub-module `sync_fifo` (parameters `WIDTH`, `DEPTH`; ports push, pop, clear, full, empty, count; synchronous active-high `rst`). Instantiated twice:
  - tag FIFO, `WIDTH = TAG_W`;
  - result FIFO, `WIDTH = TAG_W + 16`.

## Test plan
The bench models the adder with fixed latency 4.
- Single op: a=0x3C00, b=0x4000, tag=3 → one `add_valid` pulse; `m_y`=0x4200, `m_tag`=3 arriving 6 cycles after accept.
- Back-to-back: 8 ops with tags 0..7, `m_ready`=1 → one result per cycle, tags 0..7 in order, `s_ready` never drops.
- Backpressure: `m_ready`=0, DEPTH=8 → exactly 8 accepts, then `s_ready`=0. Raising `m_ready` drains 8 results in order, and `s_ready` returns 1 the cycle after the first pop.
- Flush with 3 in flight and 2 buffered → `busy` high, no `m_valid`. All 3 late results are dropped; RUN resumes and `err` stays 0.
- Spurious `add_ready` after reset with nothing outstanding → `err`=1 and held until `rst`; no `m_valid`.
- With `FP16_DRV_SUB_EN`: a=0x4200, b=0x3C00, `s_op`=1 → `add_b`=0xBC00, `m_y`=0x4000.
